// File: rtl/wfg_wishbone_master.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle out,
// one response (read data or timeout error) back on a valid/ready stream.
module wfg_wishbone_master #(
  parameter int unsigned BUSW           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  input  logic [BUSW/8-1:0] cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i,
  output logic              busy_o
);

  localparam int unsigned SELW = BUSW / 8;
  localparam int unsigned CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;

  state_e            state_q;
  logic              cyc_q, stb_q, we_q;
  logic [SELW-1:0]   sel_q;
  logic [BUSW-1:0]   adr_q, dat_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [BUSW-1:0]   rsp_dat_q;
  logic [CNTW-1:0]   cnt_q;
  logic              timeout_hit;

  // cnt_q counts completed stb cycles without ack, so it reads N-1 in the N-th stb cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            we_q    <= cmd_we_i;
            adr_q   <= cmd_adr_i;
            dat_q   <= cmd_dat_i;
            sel_q   <= cmd_sel_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a coincident timeout.
          if (wbm_ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (timeout_hit) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == IDLE) && !wb_rst_i;
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wfg_wishbone_master.sv
// Directed bench for wfg_wishbone_master against a two-register Wishbone slave model
// with programmable ack delay, a never-ack mode and a stray-ack injector.
module tb_wfg_wishbone_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack, busy;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wfg_wishbone_master #(.BUSW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat),
    .busy_o(busy)
  );

  // Slave model: ack is raised in the s_delay-th stb cycle (2 = registered-ack slave).
  logic [31:0] sregs [2];
  int unsigned s_cnt;
  int unsigned s_delay = 2;
  logic        s_ack;
  logic        s_dead = 1'b0;
  logic        stray  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      sregs[0] <= '0;
      sregs[1] <= '0;
    end
    if (rst || !(cyc && stb)) begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end else if (s_ack) begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end else begin
      s_cnt <= s_cnt + 1;
      if (!s_dead && (s_cnt + 1 == s_delay - 1)) begin
        s_ack <= 1'b1;
        if (we && !rst)
          for (int b = 0; b < 4; b++)
            if (sel[b]) sregs[adr[2]][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  assign ack  = s_ack | stray;
  assign rdat = sregs[adr[2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command and wait (bounded) for the response; counts stb-high cycles.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int stb_cyc);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    check("cmd_ready_before", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    stb_cyc = 0;
    for (int n = 0; n < 40 && !rsp_valid; n++) begin
      if (stb) stb_cyc++;
      @(posedge clk); #1;
    end
    check("rsp_valid_arrives", {31'b0, rsp_valid}, 32'd1);
    check("cyc_low_at_rsp", {31'b0, cyc}, 32'd0);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
    check("idle_after_rsp", {30'b0, busy, cmd_ready}, 32'b01);
  endtask

  int nstb;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_wbm", {28'b0, cyc, stb, we, busy}, 32'd0);
    check("rst_sel_adr", {28'b0, sel} | adr | wdat, 32'd0);
    check("rst_rsp", {30'b0, rsp_valid, rsp_err} | rsp_dat, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0; #1;
    check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Write to CFG register
    run_cmd(1'b1, 32'h4, 32'h00ABCD12, 4'hF, nstb);
    check("wr_stb_cycles", nstb, 32'd2);
    check("wr_err", {31'b0, rsp_err}, 32'd0);
    check("wr_dat", rsp_dat, 32'd0);
    check("slave_subcycle", {16'b0, sregs[1][23:8]}, 32'hABCD);
    check("slave_sync", {24'b0, sregs[1][7:0]}, 32'h12);
    take_rsp();

    run_cmd(1'b0, 32'h4, 32'h0, 4'hF, nstb);
    check("rd4_stb_cycles", nstb, 32'd2);
    check("rd4_dat", rsp_dat, 32'h00ABCD12);
    check("rd4_err", {31'b0, rsp_err}, 32'd0);
    take_rsp();

    run_cmd(1'b1, 32'h0, 32'h1, 4'hF, nstb);
    take_rsp();
    run_cmd(1'b0, 32'h0, 32'h0, 4'hF, nstb);
    check("rd0_dat", rsp_dat, 32'h1);
    take_rsp();

    // Byte-select write touches only byte 1
    run_cmd(1'b1, 32'h4, 32'hFFFFFFFF, 4'h2, nstb);
    take_rsp();
    run_cmd(1'b0, 32'h4, 32'h0, 4'hF, nstb);
    check("sel_partial_dat", rsp_dat, 32'h00ABFF12);
    take_rsp();

    // Timeout against a dead slave, then recovery
    s_dead = 1'b1;
    run_cmd(1'b0, 32'h4, 32'h0, 4'hF, nstb);
    check("to_stb_cycles", nstb, 32'd8);
    check("to_err", {31'b0, rsp_err}, 32'd1);
    check("to_dat", rsp_dat, 32'd0);
    take_rsp();
    check("to_err_held", {31'b0, rsp_err}, 32'd1);
    s_dead = 1'b0;
    run_cmd(1'b0, 32'h0, 32'h0, 4'hF, nstb);
    check("post_to_dat", rsp_dat, 32'h1);
    check("post_to_err", {31'b0, rsp_err}, 32'd0);
    take_rsp();

    // Ack in the last allowed stb cycle beats the timeout
    s_delay = 8;
    run_cmd(1'b0, 32'h4, 32'h0, 4'hF, nstb);
    check("bnd_stb_cycles", nstb, 32'd8);
    check("bnd_err", {31'b0, rsp_err}, 32'd0);
    check("bnd_dat", rsp_dat, 32'h00ABFF12);
    take_rsp();
    s_delay = 2;

    // Response backpressure with a competing command offered
    run_cmd(1'b0, 32'h0, 32'h0, 4'hF, nstb);
    cmd_we = 1'b1; cmd_adr = 32'h4; cmd_dat = 32'h5; cmd_sel = 4'hF; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_dat", rsp_dat, 32'h1);
      check("bp_no_bus", {30'b0, cyc, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    take_rsp();
    run_cmd(1'b0, 32'h4, 32'h0, 4'hF, nstb);
    check("bp_next_dat", rsp_dat, 32'h00ABFF12);
    take_rsp();

    // Stray ack while idle
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    check("stray_no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("stray_idle", {30'b0, busy, cmd_ready}, 32'b01);
    @(posedge clk); #1;
    check("stray_no_rsp2", {31'b0, rsp_valid}, 32'd0);

    // Reset while stb is high
    cmd_we = 1'b0; cmd_adr = 32'h0; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_stb_high", {31'b0, stb}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_bus_low", {29'b0, cyc, stb, busy}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0; #1;
    check("mid_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    run_cmd(1'b0, 32'h4, 32'h0, 4'hF, nstb);
    check("post_rst_dat", rsp_dat, 32'h0);
    take_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
